// File: rtl/sift_pkg.sv
// Shared constants and types for the SIFT octave-0 pixel pipeline.
// Pixel width, kernel weights/shift and default frame geometry.
package sift_pkg;

   localparam int PIX_W = 8;
   localparam int SUM_W = 12;
   localparam int CNT_W = 11;
   localparam int K_SHIFT = 4;

   localparam int DEF_WIDTH  = 1600;
   localparam int DEF_HEIGHT = 1200;

   typedef logic [PIX_W-1:0] pix_t;
   typedef logic [SUM_W-1:0] sum_t;
   typedef logic [CNT_W-1:0] cnt_t;

   localparam sum_t K_CORNER = 12'd1;
   localparam sum_t K_EDGE   = 12'd2;
   localparam sum_t K_CENTRE = 12'd4;
   localparam sum_t K_HALF   = 12'd8;

   function automatic sum_t widen(input pix_t p);
      return {{(SUM_W-PIX_W){1'b0}}, p};
   endfunction

endpackage

// File: rtl/line_buffer.sv
// DEPTH-deep pixel delay line advancing on ce; dout is the pixel
// written DEPTH accepts ago. Ports: clk, rst, ce, din, dout.
module line_buffer
   import sift_pkg::*;
#(
   parameter int DEPTH = DEF_WIDTH
) (
   input  logic clk,
   input  logic rst,
   input  logic ce,
   input  pix_t din,
   output pix_t dout
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   pix_t          mem_q [DEPTH];
   logic [AW-1:0] ptr_q;
   logic [AW-1:0] ptr_d;

   // Read-before-write at the same slot gives the oldest entry.
   assign dout = mem_q[ptr_q];

   always_comb begin
      ptr_d = ptr_q;
      if (ce) begin
         ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (ce) begin
         mem_q[ptr_q] <= din;
      end
   end

endmodule

// File: rtl/gaussian_blur_3x3.sv
// Streaming 3x3 Gaussian blur, border passthrough, WIDTH+1 pixel lag.
// Ports: clk, rst, valid, din in; dout, valid_out out. Macro: GAUSS_ROUND_EN.
module gaussian_blur_3x3
   import sift_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int HEIGHT = DEF_HEIGHT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic [PIX_W-1:0] din,
   output logic [PIX_W-1:0] dout,
   output logic             valid_out
);

   localparam int FW = $clog2(WIDTH + 2);
   localparam logic [FW-1:0] FILL_MAX = FW'(WIDTH + 1);
   localparam cnt_t COL_LAST = CNT_W'(WIDTH - 1);
   localparam cnt_t ROW_LAST = CNT_W'(HEIGHT - 1);

   pix_t lb1_o;
   pix_t lb2_o;

   // Window: c0 = oldest column, c1 = centre column;
   // right column comes straight from the taps.
   pix_t c0t_q, c0m_q, c0b_q;
   pix_t c1t_q, c1m_q, c1b_q;

   logic [FW-1:0] fill_q, fill_d;
   cnt_t          row_q, row_d;
   cnt_t          col_q, col_d;
   pix_t          dout_q, dout_d;
   logic          vout_q, vout_d;

   logic primed;
   logic border;
   sum_t sum;
   sum_t sum_r;

   line_buffer #(.DEPTH(WIDTH)) u_lb1 (
      .clk  (clk),
      .rst  (rst),
      .ce   (valid),
      .din  (din),
      .dout (lb1_o)
   );

   line_buffer #(.DEPTH(WIDTH)) u_lb2 (
      .clk  (clk),
      .rst  (rst),
      .ce   (valid),
      .din  (lb1_o),
      .dout (lb2_o)
   );

   assign primed = (fill_q == FILL_MAX);

   assign border = (row_q == '0) || (row_q == ROW_LAST) ||
                   (col_q == '0) || (col_q == COL_LAST);

   always_comb begin
      sum = K_CORNER * widen(c0t_q)
          + K_EDGE   * widen(c1t_q)
          + K_CORNER * widen(lb2_o)
          + K_EDGE   * widen(c0m_q)
          + K_CENTRE * widen(c1m_q)
          + K_EDGE   * widen(lb1_o)
          + K_CORNER * widen(c0b_q)
          + K_EDGE   * widen(c1b_q)
          + K_CORNER * widen(din);
`ifdef GAUSS_ROUND_EN
      sum_r = sum + K_HALF;
`else
      sum_r = sum;
`endif
   end

   always_comb begin
      fill_d = fill_q;
      row_d  = row_q;
      col_d  = col_q;
      dout_d = dout_q;
      vout_d = 1'b0;
      if (valid) begin
         if (!primed) begin
            fill_d = fill_q + 1'b1;
         end else begin
            vout_d = 1'b1;
            dout_d = border ? c1m_q : sum_r[SUM_W-1:K_SHIFT];
            if (col_q == COL_LAST) begin
               col_d = '0;
               row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
               col_d = col_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fill_q <= '0;
         row_q  <= '0;
         col_q  <= '0;
         dout_q <= '0;
         vout_q <= 1'b0;
         c0t_q  <= '0;
         c0m_q  <= '0;
         c0b_q  <= '0;
         c1t_q  <= '0;
         c1m_q  <= '0;
         c1b_q  <= '0;
      end else begin
         fill_q <= fill_d;
         row_q  <= row_d;
         col_q  <= col_d;
         dout_q <= dout_d;
         vout_q <= vout_d;
         if (valid) begin
            c0t_q <= c1t_q;
            c0m_q <= c1m_q;
            c0b_q <= c1b_q;
            c1t_q <= lb2_o;
            c1m_q <= lb1_o;
            c1b_q <= din;
         end
      end
   end

   assign dout      = dout_q;
   assign valid_out = vout_q;

endmodule
